// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port, single clock, byte enables,
// 1- or 2-cycle read latency and a zero-fill sweep after reset. Parity: DUAL_PORT_RAM_PARITY_EN.
module dual_port_ram #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_busy,
  input  logic                             wr_cs,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_cs,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
`ifdef DUAL_PORT_RAM_PARITY_EN
  ,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0] rd_perr,
  input  logic                             inj_perr
`endif
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_ok, rd_ok, wr_in_range, rd_in_range, collide;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_sel, rd_word;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_busy    = 1'b0;
    case (state)
      S_INIT: begin
        init_busy    = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == LAST_ADDR) state_nxt = S_RUN;
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Out-of-range writes are dropped; out-of-range reads still complete with zero data.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    wr_ok       = wr_cs & wr_en & ~init_busy & ~rst & wr_in_range;
    rd_ok       = rd_cs & rd_en & ~init_busy & ~rst;
    collide     = wr_ok & (wr_addr == rd_addr);
    wr_old      = mem[wr_addr];
    wr_merged   = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_sel  = (WRITE_FIRST != 0 && collide) ? wr_merged : mem[rd_addr];
    rd_word = rd_in_range ? rd_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (init_busy && !rst) mem[init_cnt] <= '0;
    else if (wr_ok)        mem[wr_addr]  <= wr_merged;
  end

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par_merged, rd_par_sel, rd_perr_word, p1;

  // Even parity per lane; inj_perr flips the stored bit of the lanes being written.
  always_comb begin
    wr_par_merged = par_mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_par_merged[i] = (^wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ inj_perr;
    end
    rd_par_sel = (WRITE_FIRST != 0 && collide) ? wr_par_merged : par_mem[rd_addr];
    for (int i = 0; i < NB; i++) begin
      rd_perr_word[i] = rd_in_range & ((^rd_sel[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par_sel[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy && !rst) par_mem[init_cnt] <= '0;
    else if (wr_ok)        par_mem[wr_addr]  <= wr_par_merged;
  end
`endif

  // Read handshake: rd_valid pulses once per accepted read, READ_LATENCY cycles later;
  // there is no ready, so the consumer must take rd_data in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
      p1 <= '0;
`endif
    end else begin
      v1 <= rd_ok;
      if (rd_ok) begin
        d1 <= rd_word;
`ifdef DUAL_PORT_RAM_PARITY_EN
        p1 <= rd_perr_word;
`endif
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
          rd_perr  <= '0;
`endif
        end else begin
          rd_valid <= v1;
          if (v1) begin
            rd_data <= d1;
`ifdef DUAL_PORT_RAM_PARITY_EN
            rd_perr <= p1;
`endif
          end
        end
      end
    end else begin : g_lat1
      assign rd_valid = v1;
      assign rd_data  = d1;
`ifdef DUAL_PORT_RAM_PARITY_EN
      assign rd_perr  = p1;
`endif
    end
  endgenerate

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised simple dual-port RAM: one write port and one read port, sharing a single clock. It is the successor to the single-port tristate RAM and adds the following:
- separate unidirectional data buses
- byte write enables
- configurable read latency with a valid strobe
- defined read/write collision behaviour
- a hardware zero-initialisation sweep after reset

It is used as a buffer/scratchpad behind datapath blocks that need concurrent read and write.

Parameters:
- ADDR_WIDTH, 4, address bits on both ports
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
- DEPTH, 16, number of words; must be ≤ 2**ADDR_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2
- WRITE_FIRST, 0, same-address collision policy: 1 = new data, 0 = old data

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- init_busy  out  1  high while the zero-init sweep runs; both ports are ignored while high
- wr_cs  in  1  write port select
- wr_en  in  1  write enable; write occurs when wr_cs & wr_en & !init_busy
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NB  per-byte write enable; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- rd_cs  in  1  read port select
- rd_en  in  1  read enable; read accepted when rd_cs & rd_en & !init_busy
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  one-cycle pulse marking rd_data valid for one accepted read

Behaviour:
- State machine:
  - INIT: entered on any cycle where rst=1.
    - init_busy=1; an internal counter starts at 0.
    - Each cycle writes all-zero to mem[counter] and increments the counter.
    - After writing address DEPTH-1, moves to RUN. init_busy falls on the cycle after that write, so init_busy is high for exactly DEPTH cycles after rst deasserts.
  - RUN: normal operation; init_busy=0.
- Reset values: init_busy=1, rd_data=0, rd_valid=0, read pipeline flushed (pending reads discarded). rst asserted mid-sweep or mid-read restarts INIT from address 0.
- Write: on an accepted write, mem[wr_addr] lane i takes wr_data lane i where wr_be[i]=1; other lanes are kept. wr_be=0 is a legal no-op.
- Read: an accepted read at cycle N gives rd_data and rd_valid=1 at cycle N+READ_LATENCY.
  - READ_LATENCY=2 adds an output register stage; back-to-back reads are sustained at one per cycle.
  - rd_data holds its last value when rd_valid=0.
- Collision (accepted read and write, same address, same cycle):
  - WRITE_FIRST=1: returns the merged word (new lanes where wr_be=1, old lanes elsewhere).
  - WRITE_FIRST=0: returns the pre-write word.
  - The memory is updated in both cases.
- Out of range (address ≥ DEPTH):
  - Writes are dropped.
  - Reads are still accepted, return 0 and assert rd_valid.
- Requests while init_busy=1 are dropped: no write, no rd_valid.
- No backpressure: rd_valid cannot be stalled.

Optional Feature:
- Macro DUAL_PORT_RAM_PARITY_EN.
- When defined:
  - Memory stores one even-parity bit per byte lane, computed at write time. Masked lanes keep their stored parity. The init sweep writes parity 0.
  - Extra output port rd_perr (NB bits, out) is registered alongside rd_data and is valid when rd_valid=1. Bit i=1 means lane i parity mismatched. Reset value 0.
  - Extra input port inj_perr (1 bit, in): when high during an accepted write, stored parity of the written lanes is inverted (test hook).
- When undefined: no parity storage, and neither rd_perr nor inj_perr exists.

Test Plan:
- Init sweep: hold rst for 3 cycles then release → init_busy=1 for exactly 16 cycles; a read of addr 5 issued during init gives no rd_valid; reading all addresses after init returns 16'h0000.
- Write/readback at READ_LATENCY=1 and 2: write i*16'h1111 to addr i for i=0..15 with wr_be=2'b11, then read 0..15 back-to-back → rd_valid high 16 consecutive cycles, data matches, first data N+1 or N+2 respectively.
- Byte enables: write 16'hABCD to addr 3, then 16'h1234 with wr_be=2'b01 → read addr 3 = 16'hAB34.
- Collision: mem[7]=16'h00FF; same cycle write 16'hAA55 be=2'b10 and read 7 → WRITE_FIRST=1 gives 16'hAAFF, WRITE_FIRST=0 gives 16'h00FF; subsequent read gives 16'hAAFF.
- Reset mid-operation: issue reads at READ_LATENCY=2, assert rst on the cycle after the first read → no rd_valid appears, rd_data=0, init re-runs for 16 cycles, previously written data reads back 0.
- Parity (macro defined): write 16'h0101 with inj_perr=1, be=2'b11 → read returns 16'h0101 with rd_perr=2'b11; rewrite with inj_perr=0 → rd_perr=2'b00.
